// File: rtl/mux21_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 mux with a registered output channel.
// Define MUX21_ARB_BURST_LIMIT_EN to cap each owner at BURST_MAX consecutive grant cycles under contention.

module mux21_arbiter_chk #(
  parameter int BURST_MAX = 4
) (
  input logic clk,
  input logic rst,
  input logic gnt0,
  input logic gnt1,
  input logic S,
  input logic Y_valid
);

  a_burst_max_legal: assert property (@(posedge clk) BURST_MAX >= 1);

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));

  a_select_follows_gnt1: assert property (@(posedge clk) disable iff (rst) S == gnt1);

  a_reset_clears: assert property (@(posedge clk) rst |=> (!gnt0 && !gnt1 && !Y_valid));

endmodule

module mux21_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             S,
  output logic [WIDTH-1:0] Y,
  output logic             Y_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt1_q, s_q;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q;
  logic             xfer_s;
  logic             limit_s;

`ifdef MUX21_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(BURST_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign limit_s = (cnt_q == CW'(BURST_MAX));

  // Burst counter: 1 on the first grant cycle of an owner, saturating at BURST_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == IDLE) begin
      cnt_d = {CW{1'b0}};
    end else if (state_d != state_q) begin
      cnt_d = CW'(1);
    end else if (limit_s) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Burst counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign limit_s = 1'b0;
`endif

  assign xfer_s = (gnt0_q & req0) | (gnt1_q & req1);

  // Next-state: a contended tie goes to the requester that was not served last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? G0 : G1;
        end else if (req0) begin
          state_d = G0;
        end else if (req1) begin
          state_d = G1;
        end else begin
          state_d = IDLE;
        end
      end
      G0: begin
        if (req0 && !(req1 && limit_s)) begin
          state_d = G0;
        end else if (req1) begin
          state_d = G1;
        end else begin
          state_d = IDLE;
        end
      end
      G1: begin
        if (req1 && !(req0 && limit_s)) begin
          state_d = G1;
        end else if (req0) begin
          state_d = G0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Owner pointer and output-channel next values.
  always_comb begin
    last_d = last_q;
    y_d    = y_q;
    if (state_d == G0) begin
      last_d = 1'b0;
    end else if (state_d == G1) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
    if (xfer_s) begin
      y_d = s_q ? D1 : D0;
    end else begin
      y_d = y_q;
    end
  end

  // Arbiter state with grant/select decoded from the next state so they leave flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      s_q       <= 1'b0;
      y_q       <= {WIDTH{1'b0}};
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt0_q    <= (state_d == G0);
      gnt1_q    <= (state_d == G1);
      s_q       <= (state_d == G1);
      y_q       <= y_d;
      y_valid_q <= xfer_s;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign S       = s_q;
  assign Y       = y_q;
  assign Y_valid = y_valid_q;

  mux21_arbiter_chk #(
    .BURST_MAX (BURST_MAX)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .gnt0    (gnt0_q),
    .gnt1    (gnt1_q),
    .S       (s_q),
    .Y_valid (y_valid_q)
  );

endmodule

// File: tb/tb_mux21_arbiter.sv
// Directed self-checking bench for mux21_arbiter; burst expectations follow MUX21_ARB_BURST_LIMIT_EN.

module tb_mux21_arbiter;

  localparam int WIDTH     = 8;
  localparam int BURST_MAX = 4;

  logic             clk;
  logic             rst;
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] D0;
  logic [WIDTH-1:0] D1;
  logic             gnt0;
  logic             gnt1;
  logic             S;
  logic [WIDTH-1:0] Y;
  logic             Y_valid;

  int n_cmp;
  int n_err;

  mux21_arbiter #(
    .WIDTH     (WIDTH),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .D0      (D0),
    .D1      (D1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .S       (S),
    .Y       (Y),
    .Y_valid (Y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; D0 = 8'h00; D1 = 8'h00;
    tick();
    tick();
    n_cmp++;
    if ({gnt0, gnt1, S, Y_valid, Y} !== {4'b0000, 8'h00}) begin
      n_err++;
      $display("FAIL reset_state: got %h required %h", {gnt0, gnt1, S, Y_valid, Y}, {4'b0000, 8'h00});
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, S, Y_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_no_req: got %b required %b", {gnt0, gnt1, S, Y_valid}, 4'b0000);
    end
  endtask

  task automatic test_first_simultaneous();
    req0 = 1'b1; req1 = 1'b1; D0 = 8'h11; D1 = 8'h22;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, S, Y_valid} !== 4'b1000) begin
      n_err++;
      $display("FAIL first_tie_grant: got %b required %b", {gnt0, gnt1, S, Y_valid}, 4'b1000);
    end
    tick();
    n_cmp++;
    if ({Y_valid, Y} !== {1'b1, 8'h11}) begin
      n_err++;
      $display("FAIL first_tie_data: got %h required %h", {Y_valid, Y}, {1'b1, 8'h11});
    end
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_err++;
      $display("FAIL first_tie_hold: got %b required %b", {gnt0, gnt1}, 2'b10);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, Y_valid, Y} !== {3'b000, 8'h11}) begin
      n_err++;
      $display("FAIL first_tie_release: got %h required %h", {gnt0, gnt1, Y_valid, Y}, {3'b000, 8'h11});
    end
  endtask

  task automatic test_req1_only();
    req1 = 1'b1; D1 = 8'hA5; D0 = 8'h5A;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, S, Y_valid} !== 4'b0110) begin
      n_err++;
      $display("FAIL req1_grant: got %b required %b", {gnt0, gnt1, S, Y_valid}, 4'b0110);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({gnt1, Y_valid, Y} !== {2'b11, 8'hA5}) begin
        n_err++;
        $display("FAIL req1_stream[%0d]: got %h required %h", i, {gnt1, Y_valid, Y}, {2'b11, 8'hA5});
      end
    end
    req1 = 1'b0;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, S, Y_valid, Y} !== {4'b0000, 8'hA5}) begin
      n_err++;
      $display("FAIL req1_drop: got %h required %h", {gnt0, gnt1, S, Y_valid, Y}, {4'b0000, 8'hA5});
    end
  endtask

  task automatic test_handover();
    req0 = 1'b1; req1 = 1'b0; D0 = 8'h3C; D1 = 8'hC3;
    tick();
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_err++;
      $display("FAIL handover_g0: got %b required %b", {gnt0, gnt1}, 2'b10);
    end
    tick();
    n_cmp++;
    if ({gnt0, gnt1, Y_valid, Y} !== {3'b101, 8'h3C}) begin
      n_err++;
      $display("FAIL handover_g0_data: got %h required %h", {gnt0, gnt1, Y_valid, Y}, {3'b101, 8'h3C});
    end
    req0 = 1'b0; req1 = 1'b1;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, S, Y_valid} !== 4'b0110) begin
      n_err++;
      $display("FAIL handover_switch: got %b required %b", {gnt0, gnt1, S, Y_valid}, 4'b0110);
    end
    tick();
    n_cmp++;
    if ({gnt0, gnt1, Y_valid, Y} !== {3'b011, 8'hC3}) begin
      n_err++;
      $display("FAIL handover_g1_data: got %h required %h", {gnt0, gnt1, Y_valid, Y}, {3'b011, 8'hC3});
    end
    req1 = 1'b0;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, Y_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL handover_idle: got %b required %b", {gnt0, gnt1, Y_valid}, 3'b000);
    end
  endtask

  task automatic test_back_to_back();
    logic e_g0;
    logic p_g0;
    req0 = 1'b1; req1 = 1'b1; D0 = 8'h0F; D1 = 8'hF0;
    p_g0 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
`ifdef MUX21_ARB_BURST_LIMIT_EN
      e_g0 = (((i - 1) / BURST_MAX) % 2) == 0;
`else
      e_g0 = 1'b1;
`endif
      n_cmp++;
      if ({gnt0, gnt1} !== {e_g0, ~e_g0}) begin
        n_err++;
        $display("FAIL b2b_grant[%0d]: got %b required %b", i, {gnt0, gnt1}, {e_g0, ~e_g0});
      end
      if (i > 1) begin
        n_cmp++;
        if ({Y_valid, Y} !== {1'b1, (p_g0 ? 8'h0F : 8'hF0)}) begin
          n_err++;
          $display("FAIL b2b_data[%0d]: got %h required %h", i, {Y_valid, Y}, {1'b1, (p_g0 ? 8'h0F : 8'hF0)});
        end
      end
      p_g0 = e_g0;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, Y_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL b2b_idle: got %b required %b", {gnt0, gnt1, Y_valid}, 3'b000);
    end
  endtask

  task automatic test_reset_mid_burst();
    req1 = 1'b1; D1 = 8'h77; D0 = 8'h66;
    tick();
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_err++;
      $display("FAIL midrst_g1: got %b required %b", {gnt0, gnt1}, 2'b01);
    end
    tick();
    n_cmp++;
    if ({gnt1, Y_valid, Y} !== {2'b11, 8'h77}) begin
      n_err++;
      $display("FAIL midrst_g1_data: got %h required %h", {gnt1, Y_valid, Y}, {2'b11, 8'h77});
    end
    rst = 1'b1; req0 = 1'b1;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, S, Y_valid, Y} !== {4'b0000, 8'h00}) begin
      n_err++;
      $display("FAIL midrst_clear: got %h required %h", {gnt0, gnt1, S, Y_valid, Y}, {4'b0000, 8'h00});
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, S} !== 3'b100) begin
      n_err++;
      $display("FAIL midrst_tie: got %b required %b", {gnt0, gnt1, S}, 3'b100);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_first_simultaneous();
    test_req1_only();
    test_handover();
    test_back_to_back();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
